// File: rtl/alu_pkg.sv
// Shared constants for the ALU operand/result interface and the mul/div sequencer.
package alu_pkg;

  // ALU opcodes: op[3:2] selects the adder input form, op[1:0] selects the logic unit.
  localparam logic [3:0] ALU_OR   = 4'b0000;
  localparam logic [3:0] ALU_AND  = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_ADD  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0111;
  localparam logic [3:0] ALU_PASS = 4'b1111;

  // Operation select on the cmd input.
  localparam logic CMD_MUL = 1'b0;
  localparam logic CMD_DIV = 1'b1;

  // Sequencer states.
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned multiply/divide sequencer. All add/subtract work is
// issued to the shared registered ALU; this block only shifts, counts and
// assembles results. One iteration = ISSUE (ALU registers operands) followed
// by CAPTURE (consume registered OUT/CO).
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int dw = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rdy,
  input  logic          start,
  input  logic          cmd,
  input  logic [dw-1:0] opa,
  input  logic [dw-1:0] opb,
  output logic          busy,
  output logic          done,
  output logic [dw-1:0] result_lo,
  output logic [dw-1:0] result_hi,
  output logic          div_by_zero,
  output logic [3:0]    alu_op,
  output logic          alu_right,
  output logic [dw-1:0] alu_ai,
  output logic [dw-1:0] alu_bi,
  output logic          alu_ci,
  output logic          alu_rdy,
  input  logic [dw-1:0] alu_out,
  input  logic          alu_co
);

  localparam int CW = $clog2(dw);
  localparam logic [CW-1:0] LAST = CW'(dw - 1);

  // acc_q holds the product high part (mul) or the partial remainder (div);
  // mq_q holds the multiplier/product low part (mul) or dividend/quotient (div);
  // md_q holds the multiplicand (mul) or divisor (div).
  logic [1:0]    state_q,  state_d;
  logic [CW-1:0] count_q,  count_d;
  logic [dw-1:0] acc_q,    acc_d;
  logic [dw-1:0] mq_q,     mq_d;
  logic [dw-1:0] md_q,     md_d;
  logic          cmd_q,    cmd_d;
  logic          busy_q,   busy_d;
  logic          done_q,   done_d;
  logic          dbz_q,    dbz_d;
  logic [dw-1:0] lo_q,     lo_d;
  logic [dw-1:0] hi_q,     hi_d;
  logic [3:0]    op_q,     op_d;
  logic [dw-1:0] ai_q,     ai_d;
  logic [dw-1:0] bi_q,     bi_d;
  logic          ci_q,     ci_d;
  logic [dw-1:0] rem_shift_s;

  // Partial remainder shifted left with the next dividend bit; rem[dw-1] is
  // provably 0 here, so nothing is lost.
  assign rem_shift_s = {acc_q[dw-2:0], mq_q[dw-1]};

  // Next-state, datapath and ALU operand decode; everything holds while rdy=0.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    md_d    = md_q;
    cmd_d   = cmd_q;
    busy_d  = busy_q;
    done_d  = done_q;
    dbz_d   = dbz_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    op_d    = op_q;
    ai_d    = ai_q;
    bi_d    = bi_q;
    ci_d    = ci_q;
    if (rdy) begin
      case (state_q)
        S_IDLE: begin
          done_d = 1'b0;
          if (start) begin
            cmd_d   = cmd;
            acc_d   = {dw{1'b0}};
            count_d = {CW{1'b0}};
            mq_d    = (cmd == CMD_DIV) ? opa : opb;
            md_d    = (cmd == CMD_DIV) ? opb : opa;
            dbz_d   = 1'b0;
            if ((cmd == CMD_DIV) && (opb == {dw{1'b0}})) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
              dbz_d   = 1'b1;
              lo_d    = {dw{1'b1}};
              hi_d    = opa;
            end else begin
              state_d = S_ISSUE;
              busy_d  = 1'b1;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ISSUE: begin
          state_d = S_CAPTURE;
        end
        S_CAPTURE: begin
          if (cmd_q == CMD_MUL) begin
            acc_d = {alu_co, alu_out[dw-1:1]};
            mq_d  = {alu_out[0], mq_q[dw-1:1]};
          end else if (alu_co) begin
            acc_d = alu_out;
            mq_d  = {mq_q[dw-2:0], 1'b1};
          end else begin
            acc_d = rem_shift_s;
            mq_d  = {mq_q[dw-2:0], 1'b0};
          end
          if (count_q == LAST) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            lo_d    = mq_d;
            hi_d    = acc_d;
          end else begin
            state_d = S_ISSUE;
            count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end
      endcase
      // Present the operands for the coming ISSUE cycle from the updated registers.
      if (state_d == S_ISSUE) begin
        if (cmd_d == CMD_MUL) begin
          ai_d = acc_d;
          bi_d = md_d;
          ci_d = 1'b0;
          op_d = mq_d[0] ? ALU_ADD : ALU_PASS;
        end else begin
          ai_d = {acc_d[dw-2:0], mq_d[dw-1]};
          bi_d = md_d;
          ci_d = 1'b1;
          op_d = ALU_SUB;
        end
      end else begin
        op_d = op_q;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= {CW{1'b0}};
      acc_q   <= {dw{1'b0}};
      mq_q    <= {dw{1'b0}};
      md_q    <= {dw{1'b0}};
      cmd_q   <= CMD_MUL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      lo_q    <= {dw{1'b0}};
      hi_q    <= {dw{1'b0}};
      op_q    <= ALU_PASS;
      ai_q    <= {dw{1'b0}};
      bi_q    <= {dw{1'b0}};
      ci_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      md_q    <= md_d;
      cmd_q   <= cmd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      op_q    <= op_d;
      ai_q    <= ai_d;
      bi_q    <= bi_d;
      ci_q    <= ci_d;
    end
  end

  // The ALU register enable must follow rdy in the same cycle so a stall
  // also freezes the ALU's OUT/CO.
  assign alu_rdy     = rdy & (state_q == S_ISSUE);
  assign alu_right   = 1'b0;
  assign alu_op      = op_q;
  assign alu_ai      = ai_q;
  assign alu_bi      = bi_q;
  assign alu_ci      = ci_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign result_lo   = lo_q;
  assign result_hi   = hi_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq with a behavioural registered ALU.
module tb_alu_muldiv_seq;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset, rdy, start, cmd;
  logic [DW-1:0] opa, opb;
  logic          busy, done, div_by_zero;
  logic [DW-1:0] result_lo, result_hi;
  logic [3:0]    alu_op;
  logic          alu_right, alu_ci, alu_rdy;
  logic [DW-1:0] alu_ai, alu_bi;
  logic [DW-1:0] alu_out = '0;
  logic          alu_co  = 1'b0;

  int checks   = 0;
  int failures = 0;

  alu_muldiv_seq #(.dw(DW)) dut (
    .clk(clk), .reset(reset), .rdy(rdy), .start(start), .cmd(cmd),
    .opa(opa), .opb(opb), .busy(busy), .done(done),
    .result_lo(result_lo), .result_hi(result_hi), .div_by_zero(div_by_zero),
    .alu_op(alu_op), .alu_right(alu_right), .alu_ai(alu_ai), .alu_bi(alu_bi),
    .alu_ci(alu_ci), .alu_rdy(alu_rdy), .alu_out(alu_out), .alu_co(alu_co)
  );

  always #5 clk = ~clk;

  // Registered ALU model: add, subtract (AI + ~BI + CI) and pass AI with CO=0.
  always @(posedge clk) begin
    if (alu_rdy) begin
      case (alu_op)
        4'b0011: {alu_co, alu_out} <= {1'b0, alu_ai} + {1'b0, alu_bi} + {16'h0000, alu_ci};
        4'b0111: {alu_co, alu_out} <= {1'b0, alu_ai} + {1'b0, ~alu_bi} + {16'h0000, alu_ci};
        4'b1111: begin alu_co <= 1'b0; alu_out <= alu_ai; end
        default: begin alu_co <= 1'b0; alu_out <= 16'h0000; end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Issue one operation with rdy held high; returns latency, ALU issue count
  // and div_by_zero as seen in the first cycle after the start edge.
  task automatic run_op(input logic c, input logic [15:0] a, input logic [15:0] b,
                        output int lat, output int issues, output logic dbz1);
    cmd = c; opa = a; opb = b; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1; issues = 0;
    dbz1 = div_by_zero;
    if (alu_rdy) issues++;
    while (!done && lat < 200) begin
      tick();
      lat++;
      if (alu_rdy) issues++;
    end
  endtask

  typedef struct {
    string       name;
    logic        c;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] lo;
    logic [15:0] hi;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int lat, issues, cyc;
    logic dbz1;
    logic [15:0] lo_hold;

    vecs[0] = '{"mul_1234x5678", 1'b0, 16'h1234, 16'h5678, 16'h0060, 16'h0626, 1'b0, 33};
    vecs[1] = '{"mul_ffffxffff", 1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 33};
    vecs[2] = '{"mul_0xbeef",    1'b0, 16'h0000, 16'hBEEF, 16'h0000, 16'h0000, 1'b0, 33};
    vecs[3] = '{"div_1000_7",    1'b1, 16'h03E8, 16'h0007, 16'h008E, 16'h0006, 1'b0, 33};
    vecs[4] = '{"div_by_zero",   1'b1, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1};
    vecs[5] = '{"div_ffff_fffe", 1'b1, 16'hFFFF, 16'hFFFE, 16'h0001, 16'h0001, 1'b0, 33};
    vecs[6] = '{"mul_8000x2",    1'b0, 16'h8000, 16'h0002, 16'h0000, 16'h0001, 1'b0, 33};
    vecs[7] = '{"div_8000_1",    1'b1, 16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 33};
    vecs[8] = '{"div_5_9",       1'b1, 16'h0005, 16'h0009, 16'h0000, 16'h0005, 1'b0, 33};
    vecs[9] = '{"mul_3x5",       1'b0, 16'h0003, 16'h0005, 16'h000F, 16'h0000, 1'b0, 33};

    reset = 1'b1; rdy = 1'b1; start = 1'b0; cmd = 1'b0; opa = '0; opb = '0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    chk("rst_lo", {16'd0, result_lo}, 32'd0);
    chk("rst_hi", {16'd0, result_hi}, 32'd0);
    chk("rst_alu_op", {28'd0, alu_op}, 32'hF);
    chk("rst_alu_rdy", {31'd0, alu_rdy}, 32'd0);
    chk("rst_alu_ci", {31'd0, alu_ci}, 32'd0);
    chk("rst_alu_right", {31'd0, alu_right}, 32'd0);

    // Table-driven operations
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].c, vecs[i].a, vecs[i].b, lat, issues, dbz1);
      chk({vecs[i].name, "/latency"}, lat, vecs[i].lat);
      chk({vecs[i].name, "/lo"}, {16'd0, result_lo}, {16'd0, vecs[i].lo});
      chk({vecs[i].name, "/hi"}, {16'd0, result_hi}, {16'd0, vecs[i].hi});
      chk({vecs[i].name, "/dbz"}, {31'd0, div_by_zero}, {31'd0, vecs[i].dbz});
      chk({vecs[i].name, "/dbz_after_start"}, {31'd0, dbz1}, {31'd0, vecs[i].dbz});
      chk({vecs[i].name, "/busy_at_done"}, {31'd0, busy}, 32'd0);
      chk({vecs[i].name, "/alu_issues"}, issues, vecs[i].dbz ? 0 : 16);
      lo_hold = result_lo;
      tick();
      chk({vecs[i].name, "/done_pulse"}, {31'd0, done}, 32'd0);
      chk({vecs[i].name, "/lo_held"}, {16'd0, result_lo}, {16'd0, vecs[i].lo});
    end

    // Stalls in CAPTURE (5 cycles) and ISSUE (3 cycles), plus an ignored start
    cmd = 1'b0; opa = 16'h1234; opb = 16'h5678; start = 1'b1;
    tick();
    start = 1'b0; cyc = 1;
    chk("stall/busy", {31'd0, busy}, 32'd1);
    while (cyc < 4) begin tick(); cyc++; end
    rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin tick(); cyc++; end
    chk("stall/done_frozen", {31'd0, done}, 32'd0);
    chk("stall/busy_frozen", {31'd0, busy}, 32'd1);
    rdy = 1'b1;
    tick(); cyc++;
    chk("stall/issue_alu_rdy", {31'd0, alu_rdy}, 32'd1);
    rdy = 1'b0;
    #1;
    chk("stall/alu_rdy_gated", {31'd0, alu_rdy}, 32'd0);
    for (int k = 0; k < 3; k++) begin tick(); cyc++; end
    rdy = 1'b1;
    cmd = 1'b1; opb = 16'h0000; start = 1'b1;
    tick(); cyc++;
    start = 1'b0;
    while (!done && cyc < 200) begin tick(); cyc++; end
    chk("stall/latency", cyc, 41);
    chk("stall/lo", {16'd0, result_lo}, 32'h0060);
    chk("stall/hi", {16'd0, result_hi}, 32'h0626);
    chk("stall/dbz", {31'd0, div_by_zero}, 32'd0);
    tick();

    // Reset in the middle of a divide
    cmd = 1'b1; opa = 16'h03E8; opb = 16'h0007; start = 1'b1;
    tick();
    start = 1'b0; cyc = 1;
    while (cyc < 10) begin tick(); cyc++; end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst/busy", {31'd0, busy}, 32'd0);
    chk("midrst/done", {31'd0, done}, 32'd0);
    chk("midrst/lo", {16'd0, result_lo}, 32'd0);
    chk("midrst/hi", {16'd0, result_hi}, 32'd0);
    chk("midrst/alu_op", {28'd0, alu_op}, 32'hF);
    chk("midrst/alu_rdy", {31'd0, alu_rdy}, 32'd0);
    begin
      int seen = 0;
      for (int k = 0; k < 40; k++) begin
        tick();
        if (done || busy || alu_rdy) seen++;
      end
      chk("midrst/no_activity", seen, 0);
    end
    run_op(1'b0, 16'h0003, 16'h0005, lat, issues, dbz1);
    chk("postrst/latency", lat, 33);
    chk("postrst/lo", {16'd0, result_lo}, 32'h000F);
    chk("postrst/hi", {16'd0, result_hi}, 32'h0000);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
